uart_echo_checker: RTL and testbench

Synthesizable self-checking UART echo exerciser. Drives a programmable burst of bytes into a UART transmit ready/valid interface, waits for each byte to return on the UART receive interface, compares it against the expected pattern, and reports pass/fail, error count and timeout. It sits between the on-board UART and a CPU running echo firmware, for hardware bring-up without a host-side testbench.

---
 rtl/uart_echo_checker_pkg.sv | 23 ++
 rtl/uart_echo_checker_if.sv | 14 +
 rtl/uart_echo_checker_pattern.sv | 42 ++++
 rtl/uart_echo_checker.sv | 144 ++++++++++++++
 tb/tb_uart_echo_checker.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_echo_checker_pkg.sv
// Shared types and constants for the UART echo checker.
package uart_echo_checker_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} checkerStateT;

    // Right-shifting Galois feedback masks for maximal-length sequences.
    localparam logic [7:0]  LfsrTaps8  = 8'hb8;
    localparam logic [15:0] LfsrTaps16 = 16'hb400;

    function automatic logic [15:0] lfsrTaps(input int width);
        case (width)
            8:       return {8'h00, LfsrTaps8};
            16:      return LfsrTaps16;
            default: return 16'h0000;
        endcase
    endfunction

    // Bits needed to hold any value in 0..maxValue.
    function automatic int counterWidth(input int maxValue);
        return (maxValue < 2) ? 1 : $clog2(maxValue + 1);
    endfunction

endpackage

// File: rtl/uart_echo_checker_if.sv
// UART transmit/receive ready-valid pair seen by the echo checker.
interface uart_echo_checker_if #(
    parameter int DataWidth = 8
) ();
    logic [DataWidth-1:0] TxData;
    logic                 TxValid;
    logic                 TxReady;
    logic [DataWidth-1:0] RxData;
    logic                 RxValid;
    logic                 RxReady;

    modport master (output TxData, TxValid, RxReady, input TxReady, RxData, RxValid);
    modport slave  (input TxData, TxValid, RxReady, output TxReady, RxData, RxValid);
endinterface

// File: rtl/uart_echo_checker_pattern.sv
// Expected-byte generator: incrementing by default, Galois LFSR when
// UART_ECHO_CHECKER_LFSR_EN is defined.
module echo_pattern_gen
    import uart_echo_checker_pkg::*;
#(
    parameter int                   DataWidth = 8,
    parameter logic [DataWidth-1:0] Seed      = 8'h7a
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 load,
    input  logic                 advance,
    output logic [DataWidth-1:0] pattern
);

`ifdef UART_ECHO_CHECKER_LFSR_EN
    // An all-zero LFSR state never leaves zero, so a zero seed starts at one.
    localparam logic [DataWidth-1:0] StartValue = (Seed == '0) ? DataWidth'(1) : Seed;
    localparam logic [DataWidth-1:0] Taps       = DataWidth'(lfsrTaps(DataWidth));

    function automatic logic [DataWidth-1:0] nextPattern(input logic [DataWidth-1:0] v);
        return (v >> 1) ^ (v[0] ? Taps : '0);
    endfunction
`else
    localparam logic [DataWidth-1:0] StartValue = Seed;

    function automatic logic [DataWidth-1:0] nextPattern(input logic [DataWidth-1:0] v);
        return v + DataWidth'(1);
    endfunction
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pattern <= StartValue;
        end else if (load) begin
            pattern <= StartValue;
        end else if (advance) begin
            pattern <= nextPattern(pattern);
        end
    end

endmodule

// File: rtl/uart_echo_checker.sv
// Sends a burst of pattern bytes to a UART, checks each echo, reports result.
// Build option: UART_ECHO_CHECKER_LFSR_EN selects the LFSR pattern source.
module uart_echo_checker
    import uart_echo_checker_pkg::*;
#(
    parameter int                   DataWidth     = 8,
    parameter int                   NumBytes      = 16,
    parameter int                   TimeoutCycles = 100000,
    parameter logic [DataWidth-1:0] Seed          = 8'h7a
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Start,
    output logic                           Busy,
    output logic                           Done,
    output logic                           Pass,
    output logic                           TimedOut,
    output logic [$clog2(NumBytes+1)-1:0]  ErrorCount,
    output logic [DataWidth-1:0]           LastGot,
    uart_echo_checker_if.master            bus
);

    localparam int ErrW = $clog2(NumBytes + 1);
    localparam int IdxW = counterWidth(NumBytes - 1);
    localparam int TmoW = counterWidth(TimeoutCycles - 1);

    localparam logic [ErrW-1:0] ErrMax  = ErrW'(NumBytes);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    checkerStateT         state, stateNext;
    logic                 txValidQ, rxReadyQ;
    logic                 doneQ, passQ, timedOutQ;
    logic [ErrW-1:0]      errCount, errCountNext;
    logic [IdxW-1:0]      index;
    logic [TmoW-1:0]      tmoCount;
    logic [DataWidth-1:0] lastGotQ;
    logic [DataWidth-1:0] pattern;
    logic                 load, advance, timeoutHit;
    logic                 txAccept, rxAccept;

    echo_pattern_gen #(
        .DataWidth (DataWidth),
        .Seed      (Seed)
    ) patternGen (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (load),
        .advance (advance),
        .pattern (pattern)
    );

    assign txAccept = txValidQ & bus.TxReady;
    assign rxAccept = rxReadyQ & bus.RxValid;

    always_comb begin
        stateNext    = state;
        load         = 1'b0;
        advance      = 1'b0;
        timeoutHit   = 1'b0;
        errCountNext = errCount;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    stateNext    = SEND;
                    load         = 1'b1;
                    errCountNext = '0;
                end
            end
            SEND: begin
                if (txAccept) stateNext = WAIT;
            end
            WAIT: begin
                // A receive on the terminal-count cycle takes priority over timeout.
                if (rxAccept) begin
                    advance   = 1'b1;
                    stateNext = (index == LastIdx) ? DONE : SEND;
                    if (bus.RxData != pattern && errCount != ErrMax) begin
                        errCountNext = errCount + ErrW'(1);
                    end
                end else if (tmoCount == TmoLast) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            txValidQ  <= 1'b0;
            rxReadyQ  <= 1'b0;
            doneQ     <= 1'b0;
            passQ     <= 1'b0;
            timedOutQ <= 1'b0;
            errCount  <= '0;
            index     <= '0;
            tmoCount  <= '0;
            lastGotQ  <= '0;
        end else begin
            state    <= stateNext;
            txValidQ <= (stateNext == SEND);
            rxReadyQ <= (stateNext == WAIT);
            errCount <= errCountNext;

            if (load) begin
                index     <= '0;
                doneQ     <= 1'b0;
                passQ     <= 1'b0;
                timedOutQ <= 1'b0;
            end else if (advance) begin
                index <= index + IdxW'(1);
            end

            if (state != WAIT) begin
                tmoCount <= '0;
            end else if (!rxAccept && tmoCount != TmoLast) begin
                tmoCount <= tmoCount + TmoW'(1);
            end

            if (rxAccept) lastGotQ <= bus.RxData;

            // Result flags settle on the same edge that enters DONE.
            if (stateNext == DONE && state != DONE) begin
                doneQ     <= 1'b1;
                timedOutQ <= timeoutHit;
                passQ     <= (errCountNext == '0) && !timeoutHit;
            end
        end
    end

    assign Busy        = (state == SEND) || (state == WAIT);
    assign Done        = doneQ;
    assign Pass        = passQ;
    assign TimedOut    = timedOutQ;
    assign ErrorCount  = errCount;
    assign LastGot     = lastGotQ;
    assign bus.TxValid = txValidQ;
    assign bus.TxData  = txValidQ ? pattern : '0;
    assign bus.RxReady = rxReadyQ;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: loopback echo model with Tx scoreboard.
module tb_uart_echo_checker;

    localparam int NumA     = 16;
    localparam int NumB     = 4;
    localparam int ToCycles = 50;
`ifdef UART_ECHO_CHECKER_LFSR_EN
    localparam logic [7:0] SeedA = 8'h00;
`else
    localparam logic [7:0] SeedA = 8'h7a;
`endif
    localparam logic [7:0] SeedB = 8'hfe;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic       Reset;
    logic       startD   [2];
    logic       txReadyD [2];
    logic       rxValidD [2];
    logic [7:0] rxDataD  [2];
    logic       busyO [2], doneO [2], passO [2], toO [2];
    logic [7:0] lastO [2];
    logic [4:0] errA;
    logic [2:0] errB;

    uart_echo_checker_if #(.DataWidth(8)) busA ();
    uart_echo_checker_if #(.DataWidth(8)) busB ();

    assign busA.TxReady = txReadyD[0];
    assign busA.RxValid = rxValidD[0];
    assign busA.RxData  = rxDataD[0];
    assign busB.TxReady = txReadyD[1];
    assign busB.RxValid = rxValidD[1];
    assign busB.RxData  = rxDataD[1];

    uart_echo_checker #(.DataWidth(8), .NumBytes(NumA), .TimeoutCycles(ToCycles), .Seed(SeedA)) dutA (
        .Clock(Clock), .Reset(Reset), .Start(startD[0]), .Busy(busyO[0]), .Done(doneO[0]),
        .Pass(passO[0]), .TimedOut(toO[0]), .ErrorCount(errA), .LastGot(lastO[0]), .bus(busA));

    uart_echo_checker #(.DataWidth(8), .NumBytes(NumB), .TimeoutCycles(ToCycles), .Seed(SeedB)) dutB (
        .Clock(Clock), .Reset(Reset), .Start(startD[1]), .Busy(busyO[1]), .Done(doneO[1]),
        .Pass(passO[1]), .TimedOut(toO[1]), .ErrorCount(errB), .LastGot(lastO[1]), .bus(busB));

    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         overlap = 0;
    int         holdViol = 0;
    int         sent [2];
    int         dropIdx [2];
    int         hsCycle [2];
    logic [15:0] corruptD [2];
    logic [7:0] sbA [$];
    logic [7:0] sbB [$];

    typedef struct {
        int          inst;
        logic [15:0] corrupt;
        int          drop;
        int          expErr;
        logic        expPass;
        logic        expTo;
    } runVecT;

    runVecT vecs [5];

    function automatic logic [7:0] patAt(input logic [7:0] seed, input int k);
        logic [7:0] v;
`ifdef UART_ECHO_CHECKER_LFSR_EN
        v = (seed == 8'h00) ? 8'h01 : seed;
        for (int j = 0; j < k; j++) v = {1'b0, v[7:1]} ^ (v[0] ? 8'hb8 : 8'h00);
`else
        v = seed + 8'(k);
`endif
        return v;
    endfunction

    function automatic logic       txVOf(input int i); return (i == 0) ? busA.TxValid : busB.TxValid; endfunction
    function automatic logic [7:0] txDOf(input int i); return (i == 0) ? busA.TxData  : busB.TxData;  endfunction
    function automatic logic       rrOf (input int i); return (i == 0) ? busA.RxReady : busB.RxReady; endfunction
    function automatic int errOf(input int i); return (i == 0) ? int'(errA) : int'(errB); endfunction
    function automatic int numOf(input int i); return (i == 0) ? NumA : NumB; endfunction
    function automatic logic [7:0] seedOf(input int i); return (i == 0) ? SeedA : SeedB; endfunction
    function automatic int sbSize(input int i); return (i == 0) ? sbA.size() : sbB.size(); endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // One clock: capture pre-edge handshakes, advance, then run the echo model.
    task automatic step();
        logic       hs [2];
        logic       acc [2];
        logic       vPre [2];
        logic [7:0] dPre [2];
        logic [7:0] req;
        logic       rstPre;
        int         idx;
        rstPre = Reset;
        for (int i = 0; i < 2; i++) begin
            vPre[i] = txVOf(i);
            dPre[i] = txDOf(i);
            hs[i]   = (vPre[i] === 1'b1) && txReadyD[i] && (Reset === 1'b1);
            acc[i]  = rxValidD[i] && (rrOf(i) === 1'b1) && (Reset === 1'b1);
        end
        @(posedge Clock);
        #1;
        cycle++;
        for (int i = 0; i < 2; i++) begin
            if (txVOf(i) === 1'b1 && rrOf(i) === 1'b1) overlap++;
            if (rstPre && Reset && vPre[i] === 1'b1 && !txReadyD[i] &&
                (txVOf(i) !== 1'b1 || txDOf(i) !== dPre[i])) holdViol++;
            if (acc[i]) rxValidD[i] = 1'b0;
            if (hs[i]) begin
                idx = sent[i];
                sent[i]++;
                if (sbSize(i) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL txByte inst=%0d got=%h required=none", i, dPre[i]);
                end else begin
                    if (i == 0) req = sbA.pop_front();
                    else        req = sbB.pop_front();
                    check("txByte", 32'(dPre[i]), 32'(req));
                end
                if (idx == dropIdx[i]) begin
                    hsCycle[i] = cycle;
                end else begin
                    rxDataD[i]  = dPre[i] ^ {7'b0, corruptD[i][idx]};
                    rxValidD[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic prepRun(input int i, input logic [15:0] corrupt, input int drop);
        corruptD[i] = corrupt;
        dropIdx[i]  = drop;
        sent[i]     = 0;
        hsCycle[i]  = -1;
        for (int k = 0; k < numOf(i); k++) begin
            if (i == 0) sbA.push_back(patAt(SeedA, k));
            else        sbB.push_back(patAt(SeedB, k));
        end
    endtask

    task automatic launch(input int i);
        startD[i] = 1'b1;
        step();
        startD[i] = 1'b0;
        check("launchBusy", 32'(busyO[i]), 32'd1);
        check("launchDone", 32'(doneO[i]), 32'd0);
        check("launchTxValid", 32'(txVOf(i)), 32'd1);
    endtask

    task automatic waitDone(input int i);
        for (int c = 0; c < 3000; c++) begin
            if (doneO[i] === 1'b1) break;
            step();
        end
        check("runDone", 32'(doneO[i]), 32'd1);
    endtask

    task automatic clearSb(input int i);
        if (i == 0) sbA.delete();
        else        sbB.delete();
    endtask

    task automatic checkResetA(input string tag);
        check({tag, "Busy"},     32'(busyO[0]), 0);
        check({tag, "Done"},     32'(doneO[0]), 0);
        check({tag, "Pass"},     32'(passO[0]), 0);
        check({tag, "TimedOut"}, 32'(toO[0]), 0);
        check({tag, "ErrCount"}, 32'(errA), 0);
        check({tag, "LastGot"},  32'(lastO[0]), 0);
        check({tag, "TxValid"},  32'(busA.TxValid), 0);
        check({tag, "TxData"},   32'(busA.TxData), 0);
        check({tag, "RxReady"},  32'(busA.RxReady), 0);
    endtask

    initial begin
        int         i, n, lastIdx, doneCycle;
        logic [7:0] first, expLast;
        logic       stable;

        vecs[0] = '{0, 16'h0000, -1, 0,  1'b1, 1'b0};
        vecs[1] = '{0, 16'h0208, -1, 2,  1'b0, 1'b0};
        vecs[2] = '{0, 16'h0000,  5, 0,  1'b0, 1'b1};
        vecs[3] = '{1, 16'h0000, -1, 0,  1'b1, 1'b0};
        vecs[4] = '{0, 16'hffff, -1, 16, 1'b0, 1'b0};

        Reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            startD[k] = 1'b0; txReadyD[k] = 1'b1; rxValidD[k] = 1'b0; rxDataD[k] = 8'h00;
            sent[k] = 0; dropIdx[k] = -1; hsCycle[k] = -1; corruptD[k] = 16'h0;
        end
        repeat (3) step();
        checkResetA("reset");
        Reset = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            i = vecs[v].inst;
            n = numOf(i);
            prepRun(i, vecs[v].corrupt, vecs[v].drop);
            launch(i);
            waitDone(i);
            doneCycle = cycle;
            check("pass",      32'(passO[i]), 32'(vecs[v].expPass));
            check("timedOut",  32'(toO[i]),   32'(vecs[v].expTo));
            check("errCount",  32'(errOf(i)), 32'(vecs[v].expErr));
            check("busyDone",  32'(busyO[i]), 0);
            lastIdx = (vecs[v].drop >= 0) ? vecs[v].drop - 1 : n - 1;
            expLast = patAt(seedOf(i), lastIdx) ^ {7'b0, vecs[v].corrupt[lastIdx]};
            check("lastGot",   32'(lastO[i]), 32'(expLast));
            check("txLeftover", 32'(sbSize(i)), (vecs[v].drop >= 0) ? 32'(n - vecs[v].drop - 1) : 0);
            if (vecs[v].drop >= 0) check("timeoutLatency", 32'(doneCycle - hsCycle[i]), 32'(ToCycles));
            repeat (3) step();
            check("doneHeld", 32'(doneO[i]), 1);
            clearSb(i);
        end

        // TxReady stall with Start pulses in SEND and WAIT.
        txReadyD[0] = 1'b0;
        prepRun(0, 16'h0000, -1);
        launch(0);
        first = txDOf(0);
        check("stallFirstByte", 32'(first), 32'(patAt(SeedA, 0)));
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            startD[0] = (c == 10);
            step();
            if (txVOf(0) !== 1'b1 || txDOf(0) !== first) stable = 1'b0;
        end
        startD[0] = 1'b0;
        check("stallStable", 32'(stable), 1);
        txReadyD[0] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (sent[0] >= 3 && rrOf(0) === 1'b1) break;
            step();
        end
        check("midRunWait", 32'(rrOf(0)), 1);
        startD[0] = 1'b1;
        step();
        startD[0] = 1'b0;
        waitDone(0);
        check("stallPass", 32'(passO[0]), 1);
        check("stallErr", 32'(errA), 0);
        check("stallLeftover", 32'(sbSize(0)), 0);
        clearSb(0);

        // Reset while waiting on a dropped echo.
        prepRun(0, 16'h0001, 3);
        launch(0);
        for (int c = 0; c < 200; c++) begin
            if (sent[0] >= 4) break;
            step();
        end
        repeat (5) step();
        check("preResetWait", 32'(rrOf(0)), 1);
        check("preResetErr", 32'(errA), 1);
        Reset = 1'b0;
        rxValidD[0] = 1'b0;
        step();
        checkResetA("midReset");
        Reset = 1'b1;
        clearSb(0);
        step();
        check("postResetIdle", 32'(busyO[0]), 0);

        prepRun(0, 16'h0000, -1);
        launch(0);
        waitDone(0);
        check("recoverPass", 32'(passO[0]), 1);
        clearSb(0);

        check("validReadyOverlap", 32'(overlap), 0);
        check("txHoldViolations", 32'(holdViol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
